// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared single-precision field widths and alignment FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  localparam int c_ewidth = 8;
  localparam int c_fwidth = 23;
  localparam int c_gwidth = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/brshift.sv
`default_nettype none
// ============================================================================
// Module      : brshift
// Description : Logarithmic right barrel shifter with a selectable fill bit.
// Revision    : 1.0 - initial release
// ============================================================================
module brshift #(
  parameter int SWIDTH = 5
) (
  input  logic [2**SWIDTH-1:0] din,
  input  logic [SWIDTH-1:0]    shamt,
  input  logic                 fill,
  output logic [2**SWIDTH-1:0] dout
);

  localparam int c_dw = 2**SWIDTH;

  logic [c_dw-1:0] w_stage [0:SWIDTH];

  assign w_stage[0] = din;

  for (genvar i = 0; i < SWIDTH; i++) begin : g_stage
    assign w_stage[i+1] = shamt[i] ? {{(2**i){fill}}, w_stage[i][c_dw-1:2**i]}
                                   : w_stage[i];
  end

  assign dout = w_stage[SWIDTH];

endmodule
`default_nettype wire

// File: rtl/xchg.sv
`default_nettype none
// ============================================================================
// Module      : xchg
// Description : Conditional exchange of two equal-width words.
// Revision    : 1.0 - initial release
// ============================================================================
module xchg #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              sel,
  output logic [DWIDTH-1:0] x,
  output logic [DWIDTH-1:0] y
);

  assign x = sel ? b : a;
  assign y = sel ? a : b;

endmodule
`default_nettype wire

// File: rtl/fadd_align.sv
`default_nettype none
// ============================================================================
// Module      : fadd_align
// Description : FP adder front end - orders operands by magnitude and aligns
//               the smaller mantissa with a sticky bit.
// Revision    : 1.0 - initial release
// ============================================================================
module fadd_align
  import fpu_pkg::*;
#(
  parameter int EWIDTH = c_ewidth,
  parameter int FWIDTH = c_fwidth,
  parameter int SWIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EWIDTH+FWIDTH:0]      in_a,
  input  logic [EWIDTH+FWIDTH:0]      in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EWIDTH-1:0]           out_exp,
  output logic                        out_sign_big,
  output logic                        out_eff_sub,
  output logic [FWIDTH+c_gwidth:0]    out_mbig,
  output logic [FWIDTH+c_gwidth:0]    out_msmall,
  output logic                        out_special,
  output logic                        out_swapped
);

  localparam int c_wwidth = 1 + EWIDTH + FWIDTH;
  localparam int c_mwidth = 1 + FWIDTH + c_gwidth;
  localparam int c_dwidth = 2**SWIDTH;
  localparam int c_pad    = c_dwidth - c_mwidth;
  localparam logic [EWIDTH-1:0] c_maxsh = EWIDTH'(c_dwidth - 1);

  state_t r_state, w_next;

  logic [c_wwidth-1:0] r_a, r_b, r_big, r_small;
  logic [EWIDTH-1:0]   r_diff;
  logic                r_swap;

  logic [EWIDTH-1:0]   r_exp;
  logic                r_sign_big, r_eff_sub, r_swapped;
  logic [c_mwidth-1:0] r_mbig, r_msmall;

  // ---- CMP: unpack latched operands and decide ordering ----
  logic [EWIDTH-1:0]   w_ea, w_eb, w_ea_eff, w_eb_eff, w_diff;
  logic [FWIDTH:0]     w_ma, w_mb;
  logic                w_swap;
  logic [c_wwidth-1:0] w_big, w_small;

  assign w_ea     = r_a[c_wwidth-2:FWIDTH];
  assign w_eb     = r_b[c_wwidth-2:FWIDTH];
  assign w_ea_eff = (w_ea == '0) ? EWIDTH'(1) : w_ea;
  assign w_eb_eff = (w_eb == '0) ? EWIDTH'(1) : w_eb;
  assign w_ma     = {|w_ea, r_a[FWIDTH-1:0]};
  assign w_mb     = {|w_eb, r_b[FWIDTH-1:0]};
  assign w_swap   = (w_eb_eff > w_ea_eff) || ((w_eb_eff == w_ea_eff) && (w_mb > w_ma));
  assign w_diff   = w_swap ? (w_eb_eff - w_ea_eff) : (w_ea_eff - w_eb_eff);

  xchg #(.DWIDTH(c_wwidth)) u_xchg (
    .a   (r_a),
    .b   (r_b),
    .sel (w_swap),
    .x   (w_big),
    .y   (w_small)
  );

  // ---- SHIFT: mantissa sits at the top of the shifter so low bits collect guard overflow ----
  logic [EWIDTH-1:0]   w_ebig, w_esml;
  logic [c_mwidth-1:0] w_ms;
  logic [c_dwidth-1:0] w_din, w_dout, w_mask;
  logic [SWIDTH-1:0]   w_shamt;
  logic                w_sticky;

  assign w_ebig  = r_big[c_wwidth-2:FWIDTH];
  assign w_esml  = r_small[c_wwidth-2:FWIDTH];
  assign w_ms    = {|w_esml, r_small[FWIDTH-1:0], {c_gwidth{1'b0}}};
  assign w_din   = {w_ms, {c_pad{1'b0}}};
  assign w_shamt = (r_diff > c_maxsh) ? '1 : r_diff[SWIDTH-1:0];

  brshift #(.SWIDTH(SWIDTH)) u_brshift (
    .din   (w_din),
    .shamt (w_shamt),
    .fill  (1'b0),
    .dout  (w_dout)
  );

  assign w_mask   = ~({c_dwidth{1'b1}} << w_shamt);
  assign w_sticky = (|w_dout[c_pad:0]) | (|(w_din & w_mask));

  // ---- FSM ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = CMP;
      CMP:     w_next = SHIFT;
      SHIFT:   w_next = HOLD;
      HOLD:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_big      <= '0;
      r_small    <= '0;
      r_diff     <= '0;
      r_swap     <= 1'b0;
      r_exp      <= '0;
      r_sign_big <= 1'b0;
      r_eff_sub  <= 1'b0;
      r_swapped  <= 1'b0;
      r_mbig     <= '0;
      r_msmall   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      if (r_state == CMP) begin
        r_big   <= w_big;
        r_small <= w_small;
        r_diff  <= w_diff;
        r_swap  <= w_swap;
      end
      if (r_state == SHIFT) begin
        r_exp      <= (w_ebig == '0) ? EWIDTH'(1) : w_ebig;
        r_sign_big <= r_big[c_wwidth-1];
        r_eff_sub  <= r_big[c_wwidth-1] ^ r_small[c_wwidth-1];
        r_swapped  <= r_swap;
        r_mbig     <= {|w_ebig, r_big[FWIDTH-1:0], {c_gwidth{1'b0}}};
        r_msmall   <= {w_dout[c_dwidth-1:c_pad+1], w_sticky};
      end
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == HOLD);
  assign out_exp      = r_exp;
  assign out_sign_big = r_sign_big;
  assign out_eff_sub  = r_eff_sub;
  assign out_mbig     = r_mbig;
  assign out_msmall   = r_msmall;
  assign out_swapped  = r_swapped;
  assign out_special  = (&r_a[c_wwidth-2:FWIDTH]) | (&r_b[c_wwidth-2:FWIDTH]);

endmodule
`default_nettype wire

// File: tb/tb_fadd_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_fadd_align
// Description : Directed and randomized checks of fadd_align.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd_align;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  exp;
    logic        sign_big;
    logic        eff_sub;
    logic [26:0] mbig;
    logic [26:0] msmall;
    logic        special;
    logic        swapped;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_exp;
  logic        out_sign_big, out_eff_sub, out_special, out_swapped;
  logic [26:0] out_mbig, out_msmall;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fadd_align dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_sign_big(out_sign_big), .out_eff_sub(out_eff_sub),
    .out_mbig(out_mbig), .out_msmall(out_msmall), .out_special(out_special),
    .out_swapped(out_swapped)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [65:0] pack_dut();
    return {out_exp, out_sign_big, out_eff_sub, out_mbig, out_msmall, out_special, out_swapped};
  endfunction

  function automatic logic [65:0] pack_exp(input vec_t v);
    return {v.exp, v.sign_big, v.eff_sub, v.mbig, v.msmall, v.special, v.swapped};
  endfunction

  // Reference: order by magnitude as integers, then align with plain arithmetic.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    logic [31:0] big, sml;
    longint unsigned ebig, esml, d, s, mb, ms, sh;
    v.a = a;
    v.b = b;
    v.swapped = (b[30:0] > a[30:0]);
    big = v.swapped ? b : a;
    sml = v.swapped ? a : b;
    ebig = (big[30:23] == 0) ? 1 : longint'(big[30:23]);
    esml = (sml[30:23] == 0) ? 1 : longint'(sml[30:23]);
    d = ebig - esml;
    s = (d > 31) ? 31 : d;
    mb = ((big[30:23] != 0) ? (longint'(1) << 26) : 0) + longint'(big[22:0]) * 8;
    ms = ((sml[30:23] != 0) ? (longint'(1) << 26) : 0) + longint'(sml[22:0]) * 8;
    sh = ms >> s;
    if ((sh << s) != ms) sh = sh | 1;
    v.exp      = 8'(ebig);
    v.sign_big = big[31];
    v.eff_sub  = a[31] ^ b[31];
    v.mbig     = 27'(mb);
    v.msmall   = 27'(sh);
    v.special  = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int hold, input string name);
    int t = 0;
    logic [65:0] snap;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check({name, " ready_timeout"}, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_a = v.a;
    in_b = v.b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    check({name, " valid_c1"}, out_valid, 1'b0);
    @(negedge clk);
    check({name, " valid_c2"}, out_valid, 1'b0);
    @(negedge clk);
    check({name, " valid_c3"}, out_valid, 1'b1);
    check({name, " data"}, pack_dut(), pack_exp(v));
    snap = pack_exp(v);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, " hold_stable"}, {in_ready, out_valid, pack_dut()}, {1'b0, 1'b1, snap});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " ready_after"}, {in_ready, out_valid}, 2'b10);
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] ra, rb;
    int e;

    // directed vectors with hand-derived expectations
    tbl.push_back('{32'h3F800000, 32'h3F000000, 8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h2000000, 1'b0, 1'b0});
    tbl.push_back('{32'h3F000000, 32'h3F800000, 8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h2000000, 1'b0, 1'b1});
    tbl.push_back('{32'h3F800000, 32'h2B800000, 8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h0000001, 1'b0, 1'b0});
    tbl.push_back('{32'h3FC00000, 32'hBF800000, 8'h7F, 1'b0, 1'b1, 27'h6000000, 27'h4000000, 1'b0, 1'b0});
    tbl.push_back('{32'h40000000, 32'hC0000000, 8'h80, 1'b0, 1'b1, 27'h4000000, 27'h4000000, 1'b0, 1'b0});
    tbl.push_back('{32'h00000001, 32'h00800000, 8'h01, 1'b0, 1'b0, 27'h4000000, 27'h0000008, 1'b0, 1'b1});
    tbl.push_back('{32'h7F800000, 32'h3F800000, 8'hFF, 1'b0, 1'b0, 27'h4000000, 27'h0000001, 1'b1, 1'b0});
    tbl.push_back('{32'h3F800000, 32'h32000000, 8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h0000001, 1'b0, 1'b0});
    tbl.push_back('{32'h3F800000, 32'h32FFFFFF, 8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h0000001, 1'b0, 1'b0});
    tbl.push_back('{32'h3F800000, 32'h33000000, 8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h0000002, 1'b0, 1'b0});
    tbl.push_back('{32'h3F800000, 32'h00000000, 8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h0000000, 1'b0, 1'b0});
    tbl.push_back('{32'h00000000, 32'h00000000, 8'h01, 1'b0, 1'b0, 27'h0000000, 27'h0000000, 1'b0, 1'b0});

    // randomized vectors, half with nearby exponents to hit the shift boundaries
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) begin
        e = int'(ra[30:23]) - int'($urandom_range(0, 34));
        if (e < 0) e = 0;
        rb[30:23] = 8'(e);
        if (i % 4 == 1) begin
          ra = rb;
          rb = $urandom;
          rb[30:23] = ra[30:23];
        end
      end
      tbl.push_back(model(ra, rb));
    end

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {in_ready, out_valid, pack_dut()}, {1'b1, 1'b0, 66'd0});
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], 0, $sformatf("vec%0d", i));

    // back-pressure: result held for five cycles
    run_vec(tbl[0], 5, "backpressure");

    // reset while in SHIFT aborts the operation
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'h3F800000;
    in_b = 32'h3F000000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_shift", {in_ready, out_valid, pack_dut()}, {1'b1, 1'b0, 66'd0});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_result", out_valid, 1'b0);
    end

    // reset dominates in_valid in the same cycle
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid", {in_ready, out_valid}, 2'b10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_vs_valid_idle", {in_ready, out_valid}, 2'b10);
    end

    // normal operation resumes after the aborts
    run_vec(tbl[3], 1, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fadd_align.md
FADD_ALIGN -- requirements
Module: fadd_align

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- EWIDTH, 8, exponent width.
- FWIDTH, 23, stored fraction width.
- SWIDTH, 5, shifter select width; shifter data width is 2**SWIDTH.
REQ-002 SHALL have one clock and a synchronous, active-high reset. Ports, one per line (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, operand pair valid.
- in_ready, out, 1, block accepts operand pair.
- in_a, in, 32, IEEE-754 single operand A.
- in_b, in, 32, IEEE-754 single operand B.
- out_valid, out, 1, aligned result valid.
- out_ready, in, 1, consumer accepts result.
- out_exp, out, 8, exponent of larger-magnitude operand (effective).
- out_sign_big, out, 1, sign of larger-magnitude operand.
- out_eff_sub, out, 1, XOR of operand signs.
- out_mbig, out, 27, larger mantissa {hidden, fraction, 3'b000}.
- out_msmall, out, 27, aligned smaller mantissa; bit0 is sticky.
- out_special, out, 1, either input exponent all-ones (Inf/NaN).
- out_swapped, out, 1, B was larger so operands were exchanged.

Function
REQ-003 SHALL use FSM states IDLE, CMP, SHIFT, HOLD; reset state IDLE.
REQ-004 SHALL drive in_ready = 1 only in IDLE; in_valid&in_ready latches in_a/in_b and moves to CMP.
REQ-005 SHALL unpack in CMP: hidden = (exp!=0); effective exp = max(exp,1); compute diff = |ea-eb| at 8 bits unsigned; go to SHIFT next cycle.
REQ-006 SHALL swap when eb>ea, or eb==ea and mb>ma; equal magnitudes SHALL NOT swap.
REQ-007 SHALL form the 27-bit small mantissa {hidden, fraction, 3'b000} in SHIFT and right-shift it by min(diff,31); for diff>=27 the result bits [26:1] are 0.
REQ-008 SHALL set out_msmall[0] = OR of the shifted bit0 and every set bit shifted out (sticky); a nonzero mantissa with diff>=27 yields out_msmall = 27'h1.
REQ-009 SHALL register results and enter HOLD at the end of SHIFT; out_valid = 1 exactly in HOLD.
REQ-010 SHALL transition HOLD->IDLE on out_ready; outputs SHALL stay stable in HOLD while out_ready = 0.
REQ-011 SHALL give 3-cycle latency from accept edge to out_valid and at most one operation per 4 cycles.
REQ-012 SHALL compute out_special combinationally from latched exponents and pass it through; alignment is still performed (value don't-care).

Reset
REQ-013 SHALL on rst: state to IDLE, out_valid 0, in_ready 1 the cycle after, all data outputs 0.
REQ-014 SHALL let rst in any state abort the operation with no result emitted; rst dominates in_valid and out_ready in the same cycle.

Structure
REQ-015 SHALL place EWIDTH, FWIDTH, the guard-extension width 3, and the state encoding in shared package fpu_pkg.
REQ-016 SHALL instantiate the existing brshift (SWIDTH=5, filler=0) for alignment and xchg (DWIDTH=32) for the operand swap; the sticky mask is local logic.

Verification
REQ-017 SHALL cover: a=0x3F800000, b=0x3F000000 -> out_exp=0x7F, out_mbig=0x4000000, out_msmall=0x2000000, out_swapped=0, out_valid 3 cycles after accept.
REQ-018 SHALL cover: a=0x3F000000, b=0x3F800000 -> same mantissas and exponent as REQ-017, out_swapped=1.
REQ-019 SHALL cover: a=0x3F800000, b=0x2B800000 (diff 40) -> out_msmall=0x0000001.
REQ-020 SHALL cover: a=0x3FC00000, b=0xBF800000 -> out_swapped=0, out_eff_sub=1, out_sign_big=0, out_msmall=0x4000000.
REQ-021 SHALL cover: out_ready held 0 for 5 cycles -> out_valid and all data stable, in_ready=0; after handshake, in_ready=1 next cycle.
REQ-022 SHALL cover: rst asserted while in SHIFT -> next cycle out_valid=0, in_ready=1, and no result is ever presented.
